mixcol_engine: RTL and testbench

Sequential AES MixColumns engine that operates on a full 128-bit state rather than a single 32-bit column. It processes COLS_PER_CYCLE columns per clock and uses a valid/ready handshake on both its input and output. A per-transaction mode bit selects forward MixColumns or, when the optional feature is compiled in, InvMixColumns. It sits between ShiftRows and AddRoundKey in the iterative round datapath.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/mixcol_col.sv | 53 +++++
 rtl/mixcol_engine.sv | 149 ++++++++++++++
 tb/tb_mixcol_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg
// Shared definitions for the AES MixColumns datapath:
//   - GF(2^8) reduction constant for the polynomial x^8+x^4+x^3+x+1 (0x11B)
//   - xtime / gf_mul helper functions used by the column transform
//   - FSM state encoding of the MixColumns engine
//   - column slicing helper: column c of a 128-bit state sits at
//     bits [127-32c -: 32], byte s0 of the state is bits [127:120]
package aes_pkg;

  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8), reducing when the top bit falls off.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // LSB position of column c inside the 128-bit state (96, 64, 32, 0).
  function automatic logic [6:0] col_lsb(input logic [1:0] c);
    return 7'd96 - {c, 5'b00000};
  endfunction

endpackage

// File: rtl/mixcol_col.sv
// mixcol_col
// Combinational MixColumns transform of a single 32-bit AES column.
// Byte a0 is col[31:24], a3 is col[7:0]; the result uses the same order.
// Ports:
//   col    - input column
//   inv    - 1 selects InvMixColumns (only when MIXCOL_INV_EN is defined)
//   result - transformed column
// Configuration macro: MIXCOL_INV_EN builds the inverse multipliers; without
// it the module always performs forward MixColumns and inv is ignored.
module mixcol_col
  import aes_pkg::*;
(
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] result
);

  logic [7:0] a   [4];
  logic [7:0] fwd [4];

  assign a[0] = col[31:24];
  assign a[1] = col[23:16];
  assign a[2] = col[15:8];
  assign a[3] = col[7:0];

  // Forward: r_i = 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3), with 3*x = xtime(x)^x.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fwd[i] = xtime(a[i]) ^ xtime(a[2'(i + 1)]) ^ a[2'(i + 1)]
             ^ a[2'(i + 2)] ^ a[2'(i + 3)];
    end
  end

`ifdef MIXCOL_INV_EN
  logic [7:0] bwd [4];

  // Inverse: r_i = 0e*a_i ^ 0b*a_(i+1) ^ 0d*a_(i+2) ^ 09*a_(i+3).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bwd[i] = gf_mul(a[i], 8'h0E) ^ gf_mul(a[2'(i + 1)], 8'h0B)
             ^ gf_mul(a[2'(i + 2)], 8'h0D) ^ gf_mul(a[2'(i + 3)], 8'h09);
    end
  end

  assign result = inv ? {bwd[0], bwd[1], bwd[2], bwd[3]}
                      : {fwd[0], fwd[1], fwd[2], fwd[3]};
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign result = {fwd[0], fwd[1], fwd[2], fwd[3]};
`endif

endmodule

// File: rtl/mixcol_engine.sv
// mixcol_engine
// Sequential AES MixColumns engine over a full 128-bit state, transforming
// COLS_PER_CYCLE columns per clock with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - input handshake; in_state/in_inv sampled on accept
//   in_state            - state, column c = bits [127-32c -: 32]
//   in_inv              - 1 = InvMixColumns (honoured only with MIXCOL_INV_EN)
//   out_valid/out_ready - output handshake; out_state held stable until taken
//   out_state           - transformed state (registered)
//   busy                - high while columns are being transformed
// Parameter COLS_PER_CYCLE: 1, 2 or 4; block latency is 4/COLS_PER_CYCLE.
// Configuration macro: MIXCOL_INV_EN enables the per-block inverse mode;
// without it every block is forward MixColumns and in_inv is ignored.
module mixcol_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NCYC = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_CNT = 2'(NCYC - 1);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  state_t       state;
  logic [127:0] work;
  logic [127:0] next_work;
  logic [1:0]   cnt;
  logic [1:0]   base;
  logic         mode;
  logic         idle_rdy;
  logic [31:0]  col_in  [COLS_PER_CYCLE];
  logic [31:0]  col_out [COLS_PER_CYCLE];

  // First column handled this cycle; for COLS_PER_CYCLE=4 cnt stays 0.
  assign base = 2'(int'(cnt) * COLS_PER_CYCLE);

  generate
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign col_in[g] = work[col_lsb(base + 2'(g)) +: 32];

      mixcol_col u_col (
        .col    (col_in[g]),
        .inv    (mode),
        .result (col_out[g])
      );
    end
  endgenerate

  // Working register with the current group of columns replaced in place.
  always_comb begin
    next_work = work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      next_work[col_lsb(base + 2'(g)) +: 32] = col_out[g];
    end
  end

  // idle_rdy is registered so in_ready stays low while rst_n is asserted;
  // in DONE the engine can take a new block on the output handshake edge.
  assign in_ready  = idle_rdy | ((state == DONE) & out_ready);
  assign out_state = work;

`ifndef MIXCOL_INV_EN
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign mode = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      idle_rdy  <= 1'b0;
`ifdef MIXCOL_INV_EN
      mode      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          idle_rdy <= 1'b1;
          if (in_valid && idle_rdy) begin
            work     <= in_state;
            cnt      <= '0;
            state    <= BUSY;
            busy     <= 1'b1;
            idle_rdy <= 1'b0;
`ifdef MIXCOL_INV_EN
            mode     <= in_inv;
`endif
          end
        end
        BUSY: begin
          work <= next_work;
          if (cnt == LAST_CNT) begin
            cnt       <= '0;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work  <= in_state;
              cnt   <= '0;
              state <= BUSY;
              busy  <= 1'b1;
`ifdef MIXCOL_INV_EN
              mode  <= in_inv;
`endif
            end else begin
              state    <= IDLE;
              idle_rdy <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          idle_rdy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mixcol_engine.sv
// tb_mixcol_engine
// Directed self-checking bench for mixcol_engine. Three instances are built
// with COLS_PER_CYCLE = 1, 2 and 4 (index 0, 1, 2) sharing clock and reset.
// Honours MIXCOL_INV_EN for the inverse-mode expectation.
module tb_mixcol_engine;

  localparam logic [127:0] BLK_A   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] BLK_A_F = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] BLK_M   = 128'h00000000ffffffffd4bf5d30db135345;
  localparam logic [127:0] BLK_M_F = 128'h00000000ffffffff046681e58e4da1bc;

  logic         clk;
  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   in_inv;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [2:0]   busy;
  logic [127:0] in_state  [3];
  logic [127:0] out_state [3];

  int compared;
  int mismatched;

  mixcol_engine #(.COLS_PER_CYCLE(1)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .in_inv(in_inv[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_state(out_state[0]), .busy(busy[0])
  );

  mixcol_engine #(.COLS_PER_CYCLE(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .in_inv(in_inv[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_state(out_state[1]), .busy(busy[1])
  );

  mixcol_engine #(.COLS_PER_CYCLE(4)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .in_inv(in_inv[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_state(out_state[2]), .busy(busy[2])
  );

  // Free-running 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers a block on instance k and returns after its accept edge, at the
  // following falling edge with in_valid dropped.
  task automatic send_block(input int k, input logic [127:0] blk, input logic inv);
    int n;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_state[k] = blk;
    in_inv[k]   = inv;
    n = 0;
    while (!in_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  // Counts clock edges after the accept edge until out_valid, bounded at 20;
  // rdy_low reports whether in_ready stayed low while waiting.
  task automatic wait_out(input int k, output int lat, output logic rdy_low);
    lat = 0;
    rdy_low = 1'b1;
    while (!out_valid[k] && lat < 20) begin
      if (in_ready[k]) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  // Completes the output handshake on instance k.
  task automatic drain(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset;
    compared++;
    if (in_ready[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready[0]);
    end
    compared++;
    if (out_valid[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid[0]);
    end
    compared++;
    if (busy[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_busy: got %b, expected 0", busy[0]);
    end
    compared++;
    if (out_state[0] !== 128'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_state: got %h, expected 0", out_state[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (in_ready[0] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL release_in_ready: got %b, expected 1", in_ready[0]);
    end
  endtask

  task automatic test_forward(input int k, input int exp_lat);
    int lat;
    logic rdy_low;
    send_block(k, BLK_A, 1'b0);
    wait_out(k, lat, rdy_low);
    compared++;
    if (lat !== exp_lat) begin
      mismatched++;
      $display("[TB] FAIL fwd_latency[%0d]: got %0d, expected %0d", k, lat, exp_lat);
    end
    compared++;
    if (rdy_low !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL fwd_in_ready_low[%0d]: got %b, expected 1", k, rdy_low);
    end
    compared++;
    if (out_state[k] !== BLK_A_F) begin
      mismatched++;
      $display("[TB] FAIL fwd_state[%0d]: got %h, expected %h", k, out_state[k], BLK_A_F);
    end
    drain(k);
  endtask

  task automatic test_inverse;
    int lat;
    logic rdy_low;
    logic [127:0] blk;
    logic [127:0] exp;
`ifdef MIXCOL_INV_EN
    blk = BLK_A_F;
    exp = BLK_A;
`else
    blk = BLK_A;
    exp = BLK_A_F;
`endif
    send_block(0, blk, 1'b1);
    wait_out(0, lat, rdy_low);
    compared++;
    if (out_state[0] !== exp || lat !== 4) begin
      mismatched++;
      $display("[TB] FAIL inverse_mode: got %h (lat %0d), expected %h (lat 4)", out_state[0], lat, exp);
    end
    drain(0);
  endtask

  task automatic test_fixed_points;
    int lat;
    logic rdy_low;
    send_block(0, BLK_M, 1'b0);
    wait_out(0, lat, rdy_low);
    compared++;
    if (out_state[0] !== BLK_M_F || lat !== 4) begin
      mismatched++;
      $display("[TB] FAIL fixed_points: got %h (lat %0d), expected %h (lat 4)", out_state[0], lat, BLK_M_F);
    end
    drain(0);
  endtask

  task automatic test_back_to_back;
    int lat;
    logic rdy_low;
    logic stable;
    send_block(0, BLK_A, 1'b0);
    wait_out(0, lat, rdy_low);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b1 || out_state[0] !== BLK_A_F) stable = 1'b0;
    end
    compared++;
    if (stable !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL backpressure_hold: got %b/%h, expected 1/%h", out_valid[0], out_state[0], BLK_A_F);
    end
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_state[0]  = BLK_M;
    in_inv[0]    = 1'b0;
    #1;
    compared++;
    if (in_ready[0] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_in_ready: got %b, expected 1", in_ready[0]);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    compared++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_accept: got valid %b busy %b, expected valid 0 busy 1", out_valid[0], busy[0]);
    end
    wait_out(0, lat, rdy_low);
    compared++;
    if (out_state[0] !== BLK_M_F || lat !== 4) begin
      mismatched++;
      $display("[TB] FAIL b2b_result: got %h (lat %0d), expected %h (lat 4)", out_state[0], lat, BLK_M_F);
    end
    drain(0);
  endtask

  task automatic test_reset_mid_busy;
    int lat;
    logic rdy_low;
    send_block(0, BLK_A, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midbusy_reset: got valid %b ready %b busy %b, expected 0 0 0",
               out_valid[0], in_ready[0], busy[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midbusy_release: got ready %b valid %b, expected 1 0", in_ready[0], out_valid[0]);
    end
    send_block(0, BLK_M, 1'b0);
    wait_out(0, lat, rdy_low);
    compared++;
    if (out_state[0] !== BLK_M_F || lat !== 4) begin
      mismatched++;
      $display("[TB] FAIL midbusy_next: got %h (lat %0d), expected %h (lat 4)", out_state[0], lat, BLK_M_F);
    end
    drain(0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = '0;
    in_inv     = '0;
    out_ready  = '0;
    for (int k = 0; k < 3; k++) in_state[k] = '0;
    #1;
    test_reset;
    test_forward(0, 4);
    test_forward(1, 2);
    test_forward(2, 1);
    test_inverse;
    test_fixed_points;
    test_back_to_back;
    test_reset_mid_busy;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
